// File: rtl/lstm_pkg.sv
// lstm_pkg
// Shared definitions for the LSTM cell datapath: default bias word length,
// gate index constants (gate order i, f, g, o), packed bias-vector and row
// types for the default geometry, and the read-FSM state type.
package lstm_pkg;

  localparam int D_WL_DEF      = 24;
  localparam int UNITS_NUM_DEF = 5;
  localparam int GATES_NUM     = 4;

  localparam logic [1:0] GATE_I = 2'd0;
  localparam logic [1:0] GATE_F = 2'd1;
  localparam logic [1:0] GATE_G = 2'd2;
  localparam logic [1:0] GATE_O = 2'd3;

  // One gate's bias vector; unit 0 sits in the LSBs.
  typedef logic [UNITS_NUM_DEF*D_WL_DEF-1:0] bias_vec_t;
  // All gates of one row; gate 0 sits in the LSBs.
  typedef logic [GATES_NUM-1:0][UNITS_NUM_DEF*D_WL_DEF-1:0] bias_row_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rd_state_t;

endpackage

// File: rtl/bias_row_mem.sv
// bias_row_mem
// Bias storage: DEPTH rows x GATES vectors plus a per-(row, gate) loaded
// bitmap. One synchronous write port, one asynchronous whole-row read.
//   clk, rst_n     clock, async active-low reset (clears the bitmap only)
//   wr_en          write strobe; rows >= DEPTH are dropped
//   wr_gate        gate select for the write
//   wr_addr        row select for the write
//   wr_data        one gate's bias vector
//   rd_addr        row to read
//   rd_row         all gates of rd_addr, raw storage contents
//   rd_loaded      per-gate loaded flags (all 0 when rd_addr is out of range)
//   rd_in_range    rd_addr < DEPTH
module bias_row_mem #(
  parameter int VEC_W  = 120,
  parameter int GATES  = 4,
  parameter int DEPTH  = 6,
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [1:0]             wr_gate,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [VEC_W-1:0]       wr_data,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [GATES*VEC_W-1:0] rd_row,
  output logic [GATES-1:0]       rd_loaded,
  output logic                   rd_in_range
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [GATES-1:0][VEC_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0][GATES-1:0] loaded;

  logic             wr_ok;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_ok  = wr_en && ({1'b0, wr_addr} < DEPTH_C);
  assign wr_idx = wr_addr[IDX_W-1:0];

  // Storage is deliberately not reset; the bitmap alone decides validity.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_idx][wr_gate] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaded <= '0;
    end else if (wr_ok) begin
      loaded[wr_idx][wr_gate] <= 1'b1;
    end
  end

  // Out-of-range addresses are steered to row 0 so the array index never
  // leaves bounds; their loaded flags are forced low instead.
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
  assign rd_idx      = rd_in_range ? rd_addr[IDX_W-1:0] : '0;
  assign rd_row      = mem[rd_idx];
  assign rd_loaded   = rd_in_range ? loaded[rd_idx] : '0;

endmodule

// File: rtl/lstm_bias_bank.sv
// lstm_bias_bank
// Run-time-loadable bias store for the LSTM gate accumulators. Rows are
// streamed as valid/ready bursts from a registered output stage.
//   clk, rst_n   clock, async active-low reset
//   wr_en/wr_gate/wr_addr/wr_data   single-gate vector write
//   rd_start/rd_base/rd_len         burst request (len 0 means 1 row)
//   rd_busy      burst in progress
//   o_valid/o_ready                 output handshake
//   o_bias       all gate biases of the beat's row, gate 0 in the LSBs
//   o_last       final beat of the burst
//   o_err        row out of range or some gate not loaded
//
// state    | meaning
// ST_IDLE  | waiting for rd_start
// ST_BURST | issuing rows; stays until the o_last beat is accepted
module lstm_bias_bank
  import lstm_pkg::*;
#(
  parameter int D_WL      = D_WL_DEF,
  parameter int UNITS_NUM = 5,
  parameter int DEPTH     = 6,
  parameter int GATES     = 4,
  parameter int ADDR_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [1:0]                   wr_gate,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [UNITS_NUM*D_WL-1:0]    wr_data,
  input  logic                         rd_start,
  input  logic [ADDR_W-1:0]            rd_base,
  input  logic [ADDR_W-1:0]            rd_len,
  output logic                         rd_busy,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [GATES*UNITS_NUM*D_WL-1:0] o_bias,
  output logic                         o_last,
  output logic                         o_err
);

  localparam int VEC_W = UNITS_NUM*D_WL;
  localparam int ROW_W = GATES*VEC_W;

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              issue;
  logic              slot_free;
  logic              accept_last;

  logic [ROW_W-1:0]  rd_row;
  logic [GATES-1:0]  rd_loaded;
  logic              rd_in_range;
  logic [ROW_W-1:0]  row_bias;
  logic              row_err;

  bias_row_mem #(
    .VEC_W  (VEC_W),
    .GATES  (GATES),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_gate     (wr_gate),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (ptr_q),
    .rd_row      (rd_row),
    .rd_loaded   (rd_loaded),
    .rd_in_range (rd_in_range)
  );

  // Unloaded gates read as zero; any unloaded gate or a bad row flags the beat.
  always_comb begin
    row_bias = '0;
    for (int g = 0; g < GATES; g++) begin
      if (rd_loaded[g]) begin
        row_bias[g*VEC_W +: VEC_W] = rd_row[g*VEC_W +: VEC_W];
      end
    end
  end

  assign row_err     = !rd_in_range || !(&rd_loaded);
  assign slot_free   = !o_valid || o_ready;
  assign accept_last = o_valid && o_ready && o_last;
  assign rd_busy     = (state_q == ST_BURST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    issue   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_start) begin
          state_d = ST_BURST;
          ptr_d   = rd_base;
          rem_d   = (rd_len == '0) ? ADDR_W'(1) : rd_len;
        end
      end
      ST_BURST: begin
        // rem_q == 0 means every row is issued and the last beat is pending,
        // so issuing and accepting the last beat never coincide.
        if ((rem_q != '0) && slot_free) begin
          issue = 1'b1;
          ptr_d = ptr_q + ADDR_W'(1);
          rem_d = rem_q - ADDR_W'(1);
        end
        if (accept_last) begin
          if (rd_start) begin
            ptr_d = rd_base;
            rem_d = (rd_len == '0) ? ADDR_W'(1) : rd_len;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_bias  <= '0;
      o_last  <= 1'b0;
      o_err   <= 1'b0;
    end else if (issue) begin
      o_valid <= 1'b1;
      o_bias  <= row_bias;
      o_last  <= (rem_q == ADDR_W'(1));
      o_err   <= row_err;
    end else if (o_valid && o_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lstm_bias_bank.sv
// tb_lstm_bias_bank
// Directed bench for lstm_bias_bank: a reference model of the stored
// vectors and loaded flags produces the expected beat of every burst.
module tb_lstm_bias_bank;
  import lstm_pkg::*;

  localparam int VEC_W = 120;
  localparam int ROW_W = 480;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [1:0]       wr_gate;
  logic [7:0]       wr_addr;
  logic [VEC_W-1:0] wr_data;
  logic             rd_start;
  logic [7:0]       rd_base;
  logic [7:0]       rd_len;
  logic             rd_busy;
  logic             o_valid;
  logic             o_ready;
  logic [ROW_W-1:0] o_bias;
  logic             o_last;
  logic             o_err;

  int total;
  int bad;

  logic [VEC_W-1:0] mdl [6][4];
  bit               ml  [6][4];

  lstm_bias_bank dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_gate  (wr_gate),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_start (rd_start),
    .rd_base  (rd_base),
    .rd_len   (rd_len),
    .rd_busy  (rd_busy),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_bias   (o_bias),
    .o_last   (o_last),
    .o_err    (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VEC_W-1:0] pat(input int r, input int g);
    return {24'(r), 24'hC0FFEE ^ 24'(g), 24'(r*4+g), 24'h5A5A5A, 24'(g+1)};
  endfunction

  task automatic do_wr(input int g, input int a, input logic [VEC_W-1:0] d);
    wr_en   = 1'b1;
    wr_gate = g[1:0];
    wr_addr = a[7:0];
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    if (a < 6) begin
      mdl[a][g] = d;
      ml[a][g]  = 1'b1;
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < 6; r++)
      for (int g = 0; g < 4; g++) ml[r][g] = 1'b0;
  endtask

  // mode 0: o_ready always 1; mode 1: o_ready pattern 1,0,0 repeating.
  // inj: write row 2 gate 1 = inj_d before edge inj_cyc+1 of the burst.
  task automatic run_burst(input int base, input int len, input int mode,
                           input bit inj, input int inj_cyc, input logic [VEC_W-1:0] inj_d);
    logic [ROW_W-1:0] eb [16];
    bit               ee [16];
    int L, beat, cyc, row;
    L = (len == 0) ? 1 : len;
    for (int k = 0; k < L; k++) begin
      row   = (base + k) % 256;
      eb[k] = '0;
      ee[k] = 1'b0;
      if (row >= 6) begin
        ee[k] = 1'b1;
      end else begin
        for (int g = 0; g < 4; g++) begin
          if (ml[row][g]) eb[k][g*VEC_W +: VEC_W] = mdl[row][g];
          else            ee[k] = 1'b1;
        end
      end
    end
    rd_start = 1'b1;
    rd_base  = base[7:0];
    rd_len   = len[7:0];
    tick();
    rd_start = 1'b0;
    chk("start_busy", rd_busy, 1);
    chk("start_lat", o_valid, 0);
    beat = 0;
    cyc  = 0;
    while (beat < L && cyc < 200) begin
      o_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (inj && cyc == inj_cyc) begin
        wr_en = 1'b1; wr_gate = 2'd1; wr_addr = 8'd2; wr_data = inj_d;
      end
      if (inj && cyc == inj_cyc + 1) wr_en = 1'b0;
      if (o_valid) begin
        chk($sformatf("bias b%0d r%0d", beat, base + beat), o_bias, eb[beat]);
        chk($sformatf("last b%0d", beat), o_last, (beat == L-1));
        chk($sformatf("err b%0d", beat), o_err, ee[beat]);
        if (o_ready) beat++;
      end
      tick();
      cyc++;
    end
    chk("burst_done", beat, L);
    o_ready = 1'b1;
    wr_en   = 1'b0;
    chk("end_valid", o_valid, 0);
    chk("end_busy", rd_busy, 0);
    if (mode == 0) chk("cycles", cyc, L + 1);
    if (inj) begin
      mdl[2][1] = inj_d;
      ml[2][1]  = 1'b1;
    end
  endtask

  initial begin
    logic [VEC_W-1:0] t3;
    total = 0;
    bad   = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_gate = '0; wr_addr = '0; wr_data = '0;
    rd_start = 1'b0; rd_base = '0; rd_len = '0; o_ready = 1'b1;
    clear_model();
    tick(); tick();
    chk("rst_busy", rd_busy, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_bias", o_bias, 0);
    chk("rst_last", o_last, 0);
    chk("rst_err", o_err, 0);
    rst_n = 1'b1;
    tick();

    // Unloaded row, zero length -> one beat, zero, error, last.
    run_burst(2, 0, 0, 1'b0, 0, '0);

    // Load row 0, read back one row.
    t3 = 120'h000ee1ffee0f00047200060ffff950;
    do_wr(GATE_I, 0, pat(0, 0));
    do_wr(GATE_F, 0, pat(0, 1));
    do_wr(GATE_G, 0, pat(0, 2));
    do_wr(GATE_O, 0, t3);
    run_burst(0, 1, 0, 1'b0, 0, '0);

    // Load everything, then a backpressured full burst.
    for (int r = 0; r < 6; r++)
      for (int g = 0; g < 4; g++) do_wr(g, r, pat(r, g));
    run_burst(0, 6, 1, 1'b0, 0, '0);

    // Writes past DEPTH are dropped; rows past DEPTH read zero with error.
    do_wr(0, 6, 120'hDEAD);
    do_wr(1, 200, 120'hBEEF);
    run_burst(4, 4, 0, 1'b0, 0, '0);

    // Collision: write row 2 gate 1 on the edge that issues row 2.
    run_burst(0, 6, 0, 1'b1, 2, 120'h1);
    run_burst(2, 1, 0, 1'b0, 0, '0);

    // Reset during beat 3 of 6.
    rd_start = 1'b1; rd_base = 8'd0; rd_len = 8'd6;
    tick();
    rd_start = 1'b0;
    tick(); tick(); tick();
    chk("mid_valid_pre", o_valid, 1);
    chk("mid_bias_pre", o_bias, {pat(2, 3), pat(2, 2), 120'h1, pat(2, 0)});
    rst_n = 1'b0;
    #1;
    chk("mid_valid", o_valid, 0);
    chk("mid_busy", rd_busy, 0);
    chk("mid_bias", o_bias, 0);
    chk("mid_last", o_last, 0);
    clear_model();
    #1;
    rst_n = 1'b1;
    tick();
    run_burst(1, 1, 0, 1'b0, 0, '0);
    for (int g = 0; g < 4; g++) do_wr(g, 1, pat(1, g) ^ 120'hF0F0);
    run_burst(1, 1, 0, 1'b0, 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
